hv_binder: RTL and testbench
============================

HV_BINDER -- requirements
Module: hv_binder

Interface
REQ-001 Parameter HV_LENGTH, default 1024: hypervector width in bits.
REQ-002 Parameter MAX_WINDOW1_SIZE, default 12: largest supported window1_size.
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 soft_reset  in  1  synchronous, active-low clear of all state.
REQ-006 sliding_window_mode  in  1  1 = window binding; 0 = per-item pass-through.
REQ-007 window1_size  in  6  terms per window.
REQ-008 in_valid_mapper  in  1  term present this cycle.
REQ-009 im_en  in  1  use the item-memory vector for this term.
REQ-010 im_zero  in  1  term is the all-zero vector (window not yet filled).
REQ-011 shift_amount  in  6  left-rotation amount for this term.
REQ-012 im_hv  in  HV_LENGTH  item-memory vector, same cycle as im_en.
REQ-013 out_ready  in  1  downstream accepts bound_hv.
REQ-014 bound_hv  out  HV_LENGTH  bound result, registered.
REQ-015 bound_valid  out  1  bound_hv holds an unconsumed result.
REQ-016 binding_done  out  1  one-cycle pulse when a result is loaded.
REQ-017 overflow  out  1  sticky: a result was lost.

Function
REQ-018 Term value: im_zero ? all-zero : (im_en ? rotl(im_hv, shift_amount) : all-zero); the rotation is circular over HV_LENGTH bits, with bit i moving to (i+shift_amount) mod HV_LENGTH.
REQ-019 If im_en and im_zero are both high, im_zero wins.
REQ-020 FSM states: IDLE (term count 0, accumulator zero) and ACCUM (count 1..window1_size-1).
REQ-021 Sliding mode, valid term in IDLE with effective size > 1: accumulator <= term, count <= 1, go to ACCUM.
REQ-022 Sliding mode, valid term in ACCUM while count < size-1: accumulator <= accumulator XOR term, and count increments.
REQ-023 Sliding mode, valid term on the final term (count == size-1, or IDLE with size 1): load bound_hv <= accumulator XOR term (or the term alone), clear the accumulator, count <= 0, and go to IDLE.
REQ-024 Effective size: window1_size of 0 is treated as 1; values above MAX_WINDOW1_SIZE saturate to MAX_WINDOW1_SIZE.
REQ-025 Pass-through mode: every valid term loads bound_hv directly, and the FSM stays in IDLE.
REQ-026 Latency: bound_valid and binding_done assert exactly one cycle after the final term is accepted.
REQ-027 bound_valid stays high and bound_hv stays stable until a cycle with out_ready high; it clears on that edge unless a new result loads on the same edge.
REQ-028 Simultaneous events: a result loading in the same cycle that out_ready consumes the old result loads normally; bound_valid stays 1 and overflow is not set.
REQ-029 If a result loads while bound_valid=1 and out_ready=0, the new result overwrites bound_hv and overflow sets.
REQ-030 overflow clears only on reset or soft_reset.
REQ-031 Cycles without in_valid_mapper hold all state, including mid-window.
REQ-032 A toggle of sliding_window_mode mid-window discards the partial accumulator, and the FSM returns to IDLE.
REQ-033 The block has no input backpressure; terms are always accepted.

Reset
REQ-034 rst_i high (asynchronous) or soft_reset low (synchronous) puts the FSM in IDLE, sets count 0, sets the accumulator and bound_hv all-zero, and sets bound_valid, binding_done and overflow to 0.
REQ-035 A reset during a partial window discards the window; the first term after reset starts a new window.

Structure
REQ-036 Package hdc_pkg holds the HV_LENGTH default, MAX_WINDOW1_SIZE, and the enum binder_state_e {IDLE, ACCUM}.
REQ-037 Sub-module hv_rotator is a purely combinational, parameterised circular left rotation (HV_LENGTH, 6-bit amount); it is instantiated once.
REQ-038 All outputs are driven from registers; there is no combinational path from inputs to outputs.

Verification
REQ-039 Pass-through: im_hv=1, shift_amount=5, valid -> the next cycle bound_hv has only bit 5 set, bound_valid=1, binding_done=1 for one cycle.
REQ-040 Window 3: terms im_hv=1 with shifts 0, 1, 2 on consecutive cycles -> one cycle after the third term, bound_hv=0x7 and binding_done pulses once.
REQ-041 Fill phase: window 3, first two terms im_zero=1, third term im_hv=0xF with shift 4 -> bound_hv=0xF0.
REQ-042 Rotation wrap: HV_LENGTH=1024, im_hv bit 1023 set, shift 1 -> bound_hv bit 0 set.
REQ-043 Backpressure: out_ready=0, two complete windows -> the second result is in bound_hv and overflow=1; the same sequence with out_ready=1 on the loading edge -> overflow=0.
REQ-044 Mid-window reset: window 4, soft_reset low after 2 terms, then 4 fresh terms -> the result reflects only the 4 fresh terms.

Source files
------------

// File: rtl/hdc_pkg.sv
// hdc_pkg: shared hypervector widths, window limits and binder FSM states.
package hdc_pkg;
    localparam int HV_LENGTH_DEFAULT = 1024;
    localparam int MAX_WINDOW1_SIZE = 12;
    typedef enum logic {IDLE, ACCUM} binder_state_e;
endpackage

// File: rtl/hv_binder_if.sv
// hv_binder_if: term stream into the binder and bound-result stream out of it.
//   master: drives in_valid_mapper, im_en, im_zero, shift_amount, im_hv, out_ready
//   slave:  drives bound_hv, bound_valid, binding_done, overflow
interface hv_binder_if #(
    parameter int HV_LENGTH = hdc_pkg::HV_LENGTH_DEFAULT
);
    logic                 in_valid_mapper;
    logic                 im_en;
    logic                 im_zero;
    logic [5:0]           shift_amount;
    logic [HV_LENGTH-1:0] im_hv;
    logic                 out_ready;
    logic [HV_LENGTH-1:0] bound_hv;
    logic                 bound_valid;
    logic                 binding_done;
    logic                 overflow;
    modport master (
        output in_valid_mapper, im_en, im_zero, shift_amount, im_hv, out_ready,
        input  bound_hv, bound_valid, binding_done, overflow
    );
    modport slave (
        input  in_valid_mapper, im_en, im_zero, shift_amount, im_hv, out_ready,
        output bound_hv, bound_valid, binding_done, overflow
    );
endinterface

// File: rtl/hv_rotator.sv
// hv_rotator: combinational circular left rotation, bit i -> (i+amt) mod HV_LENGTH.
//   in_hv: vector, amt: rotation amount, out_hv: rotated vector
module hv_rotator #(
    parameter int HV_LENGTH = hdc_pkg::HV_LENGTH_DEFAULT
) (
    input  logic [HV_LENGTH-1:0] in_hv,
    input  logic [5:0]           amt,
    output logic [HV_LENGTH-1:0] out_hv
);
    int r;
    logic [2*HV_LENGTH-1:0] d;
    // Shifting the doubled vector makes the upper half the wrapped rotation.
    always_comb begin
        r = int'(amt) % HV_LENGTH;
        d = {in_hv, in_hv} << r;
        out_hv = d[2*HV_LENGTH-1 -: HV_LENGTH];
    end
endmodule

// File: rtl/hv_binder.sv
// hv_binder: XOR-binds rotated item-memory terms over a sliding window (or passes them through).
//   clk_i, rst_i (async, high), soft_reset (sync, low), sliding_window_mode, window1_size,
//   bus: term inputs and registered bound result with valid/done/overflow
module hv_binder #(
    parameter int HV_LENGTH = hdc_pkg::HV_LENGTH_DEFAULT,
    parameter int MAX_WINDOW1_SIZE = hdc_pkg::MAX_WINDOW1_SIZE
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       soft_reset,
    input  logic       sliding_window_mode,
    input  logic [5:0] window1_size,
    hv_binder_if.slave bus
);
    import hdc_pkg::*;
    binder_state_e state_q, state_d;
    logic [5:0] cnt_q, cnt_d, eff;
    logic [HV_LENGTH-1:0] acc_q, acc_d, hv_q, hv_d, rot, term, load_val;
    logic valid_q, valid_d, done_q, ovf_q, ovf_d, final_term, load;
    hv_rotator #(.HV_LENGTH(HV_LENGTH)) u_rot (
        .in_hv(bus.im_hv),
        .amt(bus.shift_amount),
        .out_hv(rot)
    );
    always_comb begin
        eff = window1_size == 6'd0 ? 6'd1 :
              window1_size > 6'(MAX_WINDOW1_SIZE) ? 6'(MAX_WINDOW1_SIZE) : window1_size;
        term = (bus.im_zero || !bus.im_en) ? '0 : rot;
        // >= keeps a window that shrank mid-fill from running past its new size
        final_term = state_q == IDLE ? eff == 6'd1 : cnt_q >= eff - 6'd1;
        load = bus.in_valid_mapper && (!sliding_window_mode || final_term);
        load_val = sliding_window_mode ? acc_q ^ term : term;
        state_d = state_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        // Pass-through mode keeps the window empty, so leaving sliding mode drops any partial window.
        if (!sliding_window_mode || load) begin
            state_d = IDLE;
            cnt_d = '0;
            acc_d = '0;
        end else if (bus.in_valid_mapper) begin
            state_d = ACCUM;
            cnt_d = cnt_q + 6'd1;
            acc_d = acc_q ^ term;
        end
        hv_d = load ? load_val : hv_q;
        valid_d = load || (valid_q && !bus.out_ready);
        ovf_d = ovf_q || (load && valid_q && !bus.out_ready);
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q <= '0;
            acc_q <= '0;
            hv_q <= '0;
            valid_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (!soft_reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            acc_q <= '0;
            hv_q <= '0;
            valid_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            hv_q <= hv_d;
            valid_q <= valid_d;
            done_q <= load;
            ovf_q <= ovf_d;
        end
    end
    assign bus.bound_hv = hv_q;
    assign bus.bound_valid = valid_q;
    assign bus.binding_done = done_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_hv_binder.sv
// tb_hv_binder: directed scenarios plus random traffic against a behavioural window-binding model.
module tb_hv_binder;
    localparam int N = 1024;
    localparam int MAXW = 12;
    logic clk, rst, srst_n, mode;
    logic [5:0] ws;
    int total, bad;
    int m_cnt;
    logic [N-1:0] m_acc, m_hv, one, hv;
    logic m_valid, m_done, m_ovf;
    hv_binder_if #(.HV_LENGTH(N)) bus ();
    hv_binder #(.HV_LENGTH(N), .MAX_WINDOW1_SIZE(MAXW)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .soft_reset(srst_n),
        .sliding_window_mode(mode),
        .window1_size(ws),
        .bus(bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got[127:0], exp[127:0]);
        end
    endtask
    function automatic logic [N-1:0] rotl_m(input logic [N-1:0] v, input int s);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[(i + s) % N] = v[i];
        return r;
    endfunction
    function automatic logic [N-1:0] rand_hv();
        logic [N-1:0] r;
        for (int k = 0; k < N / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction
    task automatic model_clear();
        m_cnt = 0;
        m_acc = '0;
        m_hv = '0;
        m_valid = 1'b0;
        m_done = 1'b0;
        m_ovf = 1'b0;
    endtask
    // One clock edge of the reference: a window closes when it has seen its size in terms.
    task automatic model_edge();
        logic [N-1:0] term, val;
        int e;
        logic ld;
        if (!srst_n) begin
            model_clear();
            return;
        end
        term = bus.im_zero ? '0 : (bus.im_en ? rotl_m(bus.im_hv, int'(bus.shift_amount)) : '0);
        e = ws == 0 ? 1 : (ws > MAXW ? MAXW : int'(ws));
        ld = 1'b0;
        val = '0;
        if (!mode) begin
            ld = bus.in_valid_mapper;
            val = term;
            m_cnt = 0;
            m_acc = '0;
        end else if (bus.in_valid_mapper) begin
            if (m_cnt + 1 >= e) begin
                ld = 1'b1;
                val = m_acc ^ term;
                m_cnt = 0;
                m_acc = '0;
            end else begin
                m_acc = m_acc ^ term;
                m_cnt++;
            end
        end
        m_ovf = m_ovf | (ld & m_valid & !bus.out_ready);
        m_valid = ld | (m_valid & !bus.out_ready);
        m_done = ld;
        if (ld) m_hv = val;
    endtask
    task automatic cycle(input logic v, input logic en, input logic z, input logic [5:0] sh,
                         input logic [N-1:0] h, input logic rdy);
        bus.in_valid_mapper = v;
        bus.im_en = en;
        bus.im_zero = z;
        bus.shift_amount = sh;
        bus.im_hv = h;
        bus.out_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
        check("hv", bus.bound_hv, m_hv);
        check("valid", N'(bus.bound_valid), N'(m_valid));
        check("done", N'(bus.binding_done), N'(m_done));
        check("ovf", N'(bus.overflow), N'(m_ovf));
    endtask
    task automatic idle(input logic rdy);
        cycle(1'b0, 1'b0, 1'b0, 6'd0, '0, rdy);
    endtask
    task automatic async_rst();
        rst = 1'b1;
        #1;
        model_clear();
        check("arst_hv", bus.bound_hv, '0);
        check("arst_valid", N'(bus.bound_valid), '0);
        check("arst_ovf", N'(bus.overflow), '0);
        #1 rst = 1'b0;
    endtask
    initial begin
        total = 0;
        bad = 0;
        one = 1;
        rst = 1'b1;
        srst_n = 1'b1;
        mode = 1'b0;
        ws = 6'd0;
        bus.in_valid_mapper = 1'b0;
        bus.im_en = 1'b0;
        bus.im_zero = 1'b0;
        bus.shift_amount = '0;
        bus.im_hv = '0;
        bus.out_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset_hv", bus.bound_hv, '0);
        check("reset_valid", N'(bus.bound_valid), '0);
        check("reset_done", N'(bus.binding_done), '0);
        check("reset_ovf", N'(bus.overflow), '0);
        rst = 1'b0;
        cycle(1'b1, 1'b1, 1'b0, 6'd5, one, 1'b1);
        check("pt_hv", bus.bound_hv, one << 5);
        check("pt_valid", N'(bus.bound_valid), 1);
        check("pt_done", N'(bus.binding_done), 1);
        idle(1'b1);
        check("pt_done_pulse", N'(bus.binding_done), 0);
        check("pt_consumed", N'(bus.bound_valid), 0);
        mode = 1'b1;
        ws = 6'd3;
        cycle(1'b1, 1'b1, 1'b0, 6'd0, one, 1'b1);
        check("w3_t1_done", N'(bus.binding_done), 0);
        cycle(1'b1, 1'b1, 1'b0, 6'd1, one, 1'b1);
        check("w3_t2_done", N'(bus.binding_done), 0);
        cycle(1'b1, 1'b1, 1'b0, 6'd2, one, 1'b1);
        check("w3_hv", bus.bound_hv, N'(7));
        check("w3_done", N'(bus.binding_done), 1);
        idle(1'b1);
        check("w3_done_pulse", N'(bus.binding_done), 0);
        cycle(1'b1, 1'b1, 1'b1, 6'd9, rand_hv(), 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 6'd3, rand_hv(), 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 6'd4, N'(16'hF), 1'b1);
        check("fill_hv", bus.bound_hv, N'(16'hF0));
        mode = 1'b0;
        cycle(1'b1, 1'b1, 1'b0, 6'd1, one << (N - 1), 1'b1);
        check("wrap_hv", bus.bound_hv, one);
        mode = 1'b1;
        ws = 6'd2;
        cycle(1'b1, 1'b1, 1'b0, 6'd0, N'(3), 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 6'd3, N'(3), 1'b0);
        check("bp_first", bus.bound_hv, N'(8'h1B));
        cycle(1'b1, 1'b1, 1'b0, 6'd0, N'(8'h50), 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 6'd0, N'(8'h05), 1'b0);
        check("bp_second", bus.bound_hv, N'(8'h55));
        check("bp_ovf", N'(bus.overflow), 1);
        idle(1'b0);
        check("bp_ovf_sticky", N'(bus.overflow), 1);
        srst_n = 1'b0;
        idle(1'b1);
        srst_n = 1'b1;
        check("srst_ovf", N'(bus.overflow), 0);
        check("srst_hv", bus.bound_hv, '0);
        cycle(1'b1, 1'b1, 1'b0, 6'd0, N'(3), 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 6'd3, N'(3), 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 6'd0, N'(8'h50), 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 6'd0, N'(8'h05), 1'b1);
        check("same_edge_hv", bus.bound_hv, N'(8'h55));
        check("same_edge_valid", N'(bus.bound_valid), 1);
        check("same_edge_ovf", N'(bus.overflow), 0);
        ws = 6'd4;
        cycle(1'b1, 1'b1, 1'b0, 6'd7, one, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 6'd8, one, 1'b1);
        srst_n = 1'b0;
        cycle(1'b1, 1'b1, 1'b0, 6'd9, one, 1'b1);
        srst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 6'(i), one, 1'b1);
            if (i < 3) check("mid_rst_early", N'(bus.binding_done), 0);
        end
        check("mid_rst_hv", bus.bound_hv, N'(4'hF));
        ws = 6'd0;
        cycle(1'b1, 1'b1, 1'b0, 6'd9, one, 1'b1);
        check("ws0_hv", bus.bound_hv, one << 9);
        check("ws0_done", N'(bus.binding_done), 1);
        ws = 6'd50;
        for (int i = 0; i < MAXW; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 6'(i), one, 1'b1);
            if (i < MAXW - 1) check("sat_early", N'(bus.binding_done), 0);
        end
        check("sat_hv", bus.bound_hv, N'(12'hFFF));
        ws = 6'd3;
        cycle(1'b1, 1'b1, 1'b0, 6'd0, one, 1'b1);
        idle(1'b1);
        idle(1'b1);
        cycle(1'b1, 1'b1, 1'b0, 6'd1, one, 1'b1);
        mode = 1'b0;
        idle(1'b1);
        mode = 1'b1;
        for (int i = 4; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 6'(i), one, 1'b1);
        check("toggle_hv", bus.bound_hv, N'(8'h70));
        async_rst();
        cycle(1'b1, 1'b1, 1'b0, 6'd0, one, 1'b1);
        for (int n = 0; n < 3000; n++) begin
            srst_n = $urandom_range(0, 99) != 0;
            mode = $urandom_range(0, 19) != 0;
            if ($urandom_range(0, 15) == 0) ws = $urandom_range(0, 7) == 0 ? 6'd63 : 6'($urandom_range(0, 15));
            hv = $urandom_range(0, 3) == 0 ? N'($urandom) : rand_hv();
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 7) == 0,
                  6'($urandom_range(0, 63)), hv, $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 199) == 0) async_rst();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
